lfsr_multi: RTL
===============

Name: lfsr_multi

Overview:
Parametrised LFSR engine and successor to the fixed 5-bit Fibonacci LFSR. It supports arbitrary width, Fibonacci or Galois structure, and STEPS shifts per advance. It adds a seed-return (period) detector, an all-zero lockup detector with optional auto-recovery, and a saturating advance counter. It is used as the PRBS/scrambler source in the test-pattern and whitening paths.

Parameters:
WIDTH, 16, state width in bits (2..64)
STEPS, 1, LFSR shifts applied per advance; also the width of out_bits (1..WIDTH)
COUNT_W, 32, width of the saturating advance counter
AUTO_RECOVER, 1, 1 = an advance taken in the all-zero state reloads a non-zero seed; 0 = the state stays stuck

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset; loads the seed like reinit
reinit  input  1  load initial_state, taps and mode; clear count and flags
advance  input  1  apply STEPS shifts this cycle
mode  input  1  lfsr_pkg::lfsr_mode_e, LFSR_FIB=0 or LFSR_GAL=1; captured on load
taps  input  WIDTH  feedback polynomial mask; captured on load
initial_state  input  WIDTH  seed; captured on load
out_bits  output  STEPS  out_bits[k] = state[0] after shift k+1 of the last advance
out_state  output  WIDTH  current state register
count  output  COUNT_W  advances since last load, saturating
wrapped  output  1  one-cycle pulse: the state after an advance equals the captured seed
lockup  output  1  level: out_state == 0

Behaviour:
- Priority: rst > reinit > advance > hold. All outputs are registered and change on the clock edge after the controlling input.
- Load (rst or reinit), simultaneous advance ignored:
  - state, seed_q <= initial_state; taps_q <= taps; mode_q <= mode
  - count <= 0; out_bits <= 0; wrapped <= 0
  - taps and mode are used only from taps_q/mode_q; changes between loads have no effect.
- Reset values: out_state = initial_state sampled at reset; count = 0; out_bits = 0; wrapped = 0; lockup = (initial_state == 0).
- Fibonacci single shift from s: fb = XOR-reduce(taps_q & s); s' = {s[WIDTH-2:0], fb}.
- Galois single shift from s: b = s[WIDTH-1]; s'[0] = b & taps_q[0]; s'[i] = s[i-1] ^ (b & taps_q[i]) for i ≥ 1.
- Advance, state non-zero:
  - STEPS shifts chained combinationally in one cycle; state <= result of shift STEPS.
  - out_bits[k] <= bit 0 of the intermediate after shift k+1.
  - count <= count+1, saturating at all-ones.
  - wrapped <= (new state == seed_q). Only the end state is compared, so with STEPS>1 a seed passed mid-advance is not flagged.
- Advance, state == 0:
  - AUTO_RECOVER=1: state <= seed_q if seed_q != 0, else WIDTH'(1); out_bits <= 0; count increments; wrapped <= 0.
  - AUTO_RECOVER=0: state stays 0; out_bits <= 0; count increments; wrapped <= 0.
- No advance: state, out_bits and count hold; wrapped <= 0.
- lockup is combinational from the state register: high exactly while out_state == 0.
- Reset or reinit mid-sequence takes effect on that edge; no partial shift is retained.

Decomposition:
- Package lfsr_pkg: typedef enum logic {LFSR_FIB=1'b0, LFSR_GAL=1'b1} lfsr_mode_e; shared mode constants.
- One combinational sub-module, lfsr_step (WIDTH; in: s, taps, mode; out: s_next). It is instantiated STEPS times in a generate chain.
- lfsr_multi holds all registers, the counter, the seed compare and the recovery mux.

Test Plan:
1. WIDTH=4, STEPS=1, FIB, taps=4'b1100, seed 4'b0001 -> after each advance out_state = 0010, 0100, 1001, 0011; out_bits = 0,0,1,1; wrapped pulses only after the 15th advance, with count=15.
2. Same config with STEPS=2 -> advance 1: out_state=0100, out_bits=2'b00; advance 2: out_state=0011, out_bits=2'b11.
3. WIDTH=4, GAL, taps=4'b0011, seed 4'b1000 -> out_state = 0011, 0110, 1100, 1011 on successive advances; 15th advance returns to 1000 with wrapped=1.
4. Seed 4'b0000, AUTO_RECOVER=1 -> lockup=1 after rst; one advance -> out_state=0001, lockup=0, count=1. With AUTO_RECOVER=0 -> out_state stays 0000 and lockup stays 1.
5. reinit and advance asserted together mid-sequence with initial_state=4'b0101 -> out_state=0101, count=0, wrapped=0. A taps change without reinit leaves the sequence unchanged.
6. COUNT_W=3, 9 consecutive advances -> count saturates at 3'b111. rst asserted during advance -> state = initial_state and count=0 on the next edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types for the parametrised LFSR engine.
// The mode enum selects Fibonacci or Galois feedback.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    // XOR-reduce of the tapped bits, used as the Fibonacci feedback bit
    function automatic logic tap_parity(input logic [63:0] masked);
        tap_parity = ^masked;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR shift, Fibonacci or Galois.
// The top chains STEPS copies to apply several shifts per advance.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] taps,
    input  lfsr_mode_e       mode,
    output logic [WIDTH-1:0] s_next
);

    logic             fib_fb_s;
    logic             msb_s;
    logic [63:0]      masked_s;

    // Next-state selection for the captured feedback structure
    always_comb begin
        masked_s               = 64'd0;
        masked_s[WIDTH-1:0]    = taps & s;
        fib_fb_s               = tap_parity(masked_s);
        msb_s                  = s[WIDTH-1];
        case (mode)
            LFSR_FIB: s_next = {s[WIDTH-2:0], fib_fb_s};
            LFSR_GAL: s_next = {s[WIDTH-2:0], 1'b0} ^ (taps & {WIDTH{msb_s}});
            default:  s_next = {s[WIDTH-2:0], fib_fb_s};
        endcase
    end

endmodule

// File: rtl/lfsr_multi.sv
// Parametrised multi-step LFSR with seed-return detection, all-zero
// lockup detection/recovery and a saturating advance counter.
module lfsr_multi
    import lfsr_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int STEPS        = 1,
    parameter int COUNT_W      = 32,
    parameter int AUTO_RECOVER = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reinit,
    input  logic               advance,
    input  lfsr_mode_e         mode,
    input  logic [WIDTH-1:0]   taps,
    input  logic [WIDTH-1:0]   initial_state,
    output logic [STEPS-1:0]   out_bits,
    output logic [WIDTH-1:0]   out_state,
    output logic [COUNT_W-1:0] count,
    output logic               wrapped,
    output logic               lockup
);

    logic [WIDTH-1:0]   state_r;
    logic [WIDTH-1:0]   seed_r;
    logic [WIDTH-1:0]   taps_r;
    lfsr_mode_e         mode_r;
    logic [COUNT_W-1:0] count_r;
    logic [STEPS-1:0]   bits_r;
    logic               wrapped_r;

    logic [WIDTH-1:0]   chain_s [0:STEPS];
    logic [STEPS-1:0]   bits_s;
    logic [WIDTH-1:0]   recover_s;
    logic [COUNT_W-1:0] count_next_s;

    assign chain_s[0] = state_r;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        lfsr_step #(.WIDTH(WIDTH)) u_step (
            .s      (chain_s[k]),
            .taps   (taps_r),
            .mode   (mode_r),
            .s_next (chain_s[k+1])
        );
        assign bits_s[k] = chain_s[k+1][0];
    end

    // Recovery target and saturating counter increment
    always_comb begin
        recover_s    = state_r;
        count_next_s = count_r;
        if (AUTO_RECOVER != 0) begin
            recover_s = (seed_r != {WIDTH{1'b0}}) ? seed_r : WIDTH'(1);
        end else begin
            recover_s = {WIDTH{1'b0}};
        end
        if (count_r != {COUNT_W{1'b1}}) begin
            count_next_s = count_r + COUNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Load / advance / hold sequencing of all state
    always_ff @(posedge clk) begin
        if (rst || reinit) begin
            state_r   <= initial_state;
            seed_r    <= initial_state;
            taps_r    <= taps;
            mode_r    <= mode;
            count_r   <= {COUNT_W{1'b0}};
            bits_r    <= {STEPS{1'b0}};
            wrapped_r <= 1'b0;
        end else if (advance) begin
            count_r <= count_next_s;
            if (state_r == {WIDTH{1'b0}}) begin
                // Zero is a fixed point of every LFSR; only the recovery mux can leave it
                state_r   <= recover_s;
                bits_r    <= {STEPS{1'b0}};
                wrapped_r <= 1'b0;
            end else begin
                state_r   <= chain_s[STEPS];
                bits_r    <= bits_s;
                wrapped_r <= (chain_s[STEPS] == seed_r);
            end
        end else begin
            wrapped_r <= 1'b0;
        end
    end

    assign out_state = state_r;
    assign out_bits  = bits_r;
    assign count     = count_r;
    assign wrapped   = wrapped_r;
    assign lockup    = (state_r == {WIDTH{1'b0}});

endmodule
